// File: rtl/nav_pkg.sv
// Shared encodings for the navigation controllers and the top-level mux.
// Latency: none; constants, types and one pure function.
// Backpressure: not applicable.
package nav_pkg;

  // One-hot motion command sent to the simulator over the UART link
  localparam logic [3:0] MS_STOP  = 4'b0000;
  localparam logic [3:0] MS_FWD   = 4'b0001;
  localparam logic [3:0] MS_BACK  = 4'b0010;
  localparam logic [3:0] MS_LEFT  = 4'b0100;
  localparam logic [3:0] MS_RIGHT = 4'b1000;

  // nav_state encodings
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FORWARD   = 3'd1;
  localparam logic [2:0] ST_SETTLE    = 3'd2;
  localparam logic [2:0] ST_DECIDE    = 3'd3;
  localparam logic [2:0] ST_WAIT_CMD  = 3'd4;
  localparam logic [2:0] ST_TURN_L    = 3'd5;
  localparam logic [2:0] ST_TURN_R    = 3'd6;
  localparam logic [2:0] ST_TURN_BACK = 3'd7;

  // One bit per direction, 1 = open (no obstacle)
  typedef struct packed {
    logic front;
    logic left;
    logic right;
  } dirs_t;

  // Motion command held while in a given state; a U-turn is two right turns
  function automatic logic [3:0] ms_for_state(input logic [2:0] st);
    logic [3:0] ms;
    case (st)
      ST_FORWARD:   ms = MS_FWD;
      ST_TURN_L:    ms = MS_LEFT;
      ST_TURN_R:    ms = MS_RIGHT;
      ST_TURN_BACK: ms = MS_RIGHT;
      default:      ms = MS_STOP;
    endcase
    return ms;
  endfunction

endpackage

// File: rtl/nav_edge_detect.sv
// Per-bit rising or falling edge detector against the previous-cycle sample.
// Latency: pulse is combinational from d, valid in the cycle the level changes.
// Backpressure: none; the history register updates every cycle unconditionally.
module nav_edge_detect #(
  parameter int W       = 1,
  parameter bit FALLING = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] pulse
);

  logic [W-1:0] d_q;

  // Remember last cycle's level so a level held across any event never re-fires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= '0;
    else     d_q <= d;
  end

  assign pulse = FALLING ? (d_q & ~d) : (d & ~d_q);

endmodule

// File: rtl/semi_auto_nav.sv
// Semi-automatic drive FSM: forward to junction/wall, settle, auto-turn or await user.
// Latency: outputs registered from next state, so they move with nav_state.
// Backpressure: none. SEMI_AUTO_TIMEOUT_EN adds a WAIT_CMD timeout with auto-pick.
module semi_auto_nav
  import nav_pkg::*;
#(
  parameter int unsigned TURN_CYCLES   = 90_000_000,
  parameter int unsigned SETTLE_CYCLES = 20_000_000,
  parameter int unsigned EXIT_CYCLES   = 50_000_000,
  parameter int unsigned WAIT_TIMEOUT  = 500_000_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       front_detector,
  input  logic       left_detector,
  input  logic       right_detector,
  input  logic       back_detector,
  input  logic       cmd_forward,
  input  logic       cmd_left,
  input  logic       cmd_right,
  input  logic       cmd_back,
  output logic [3:0] moving_state,
  output logic [2:0] nav_state,
  output logic       waiting
);

  // Timed states last exactly N cycles: load N-1 on entry, leave when 0.
  // The forward exit window loads N: side events count once it reaches 0.
  localparam logic [31:0] SETTLE_LD = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] TURN_LD   = 32'(TURN_CYCLES - 1);
  localparam logic [31:0] BACK_LD   = 32'(2 * TURN_CYCLES - 1);
  localparam logic [31:0] EXIT_LD   = 32'(EXIT_CYCLES);
`ifdef SEMI_AUTO_TIMEOUT_EN
  localparam logic [31:0] WAIT_LD   = 32'(WAIT_TIMEOUT - 1);
`else
  localparam logic [31:0] WAIT_LD   = 32'd0;
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(WAIT_TIMEOUT);
`endif

  // back_detector is reported by the simulator but plays no part in decisions
  logic unused_back;
  assign unused_back = back_detector;

  logic [2:0]  state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [1:0]  side_fall;
  logic [3:0]  btn_rise;
  dirs_t       open_dirs;
  logic        acc_fwd, acc_left, acc_right, acc_back;

  nav_edge_detect #(.W(2), .FALLING(1'b1)) u_side_edge (
    .clk   (sys_clk),
    .rst   (rst),
    .d     ({left_detector, right_detector}),
    .pulse (side_fall)
  );

  nav_edge_detect #(.W(4), .FALLING(1'b0)) u_btn_edge (
    .clk   (sys_clk),
    .rst   (rst),
    .d     ({cmd_forward, cmd_left, cmd_right, cmd_back}),
    .pulse (btn_rise)
  );

  assign open_dirs = ~{front_detector, left_detector, right_detector};

  // A button only counts if it points at an open direction; back always counts
  assign acc_fwd   = btn_rise[3] & open_dirs.front;
  assign acc_left  = btn_rise[2] & open_dirs.left;
  assign acc_right = btn_rise[1] & open_dirs.right;
  assign acc_back  = btn_rise[0];

  function automatic logic [31:0] load_for(input logic [2:0] st);
    logic [31:0] v;
    case (st)
      ST_SETTLE:          v = SETTLE_LD;
      ST_TURN_L, ST_TURN_R: v = TURN_LD;
      ST_TURN_BACK:       v = BACK_LD;
      ST_FORWARD:         v = EXIT_LD;
      ST_WAIT_CMD:        v = WAIT_LD;
      default:            v = 32'd0;
    endcase
    return v;
  endfunction

`ifdef SEMI_AUTO_TIMEOUT_EN
  // Unattended choice prefers straight on, then right, then left
  function automatic logic [2:0] timeout_pick(input dirs_t o);
    logic [2:0] st;
    if (o.front)      st = ST_FORWARD;
    else if (o.right) st = ST_TURN_R;
    else if (o.left)  st = ST_TURN_L;
    else              st = ST_TURN_BACK;
    return st;
  endfunction
`endif

  // Next-state decision; dropping enable overrides everything
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_SETTLE;
      ST_FORWARD: begin
        if (front_detector || ((|side_fall) && (cnt == 32'd0)))
          state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt == 32'd0) state_nxt = ST_DECIDE;
      end
      ST_DECIDE: begin
        case (open_dirs)
          3'b000:  state_nxt = ST_TURN_BACK;
          3'b100:  state_nxt = ST_FORWARD;
          3'b010:  state_nxt = ST_TURN_L;
          3'b001:  state_nxt = ST_TURN_R;
          default: state_nxt = ST_WAIT_CMD;
        endcase
      end
      ST_WAIT_CMD: begin
        if (acc_fwd)        state_nxt = ST_FORWARD;
        else if (acc_left)  state_nxt = ST_TURN_L;
        else if (acc_right) state_nxt = ST_TURN_R;
        else if (acc_back)  state_nxt = ST_TURN_BACK;
`ifdef SEMI_AUTO_TIMEOUT_EN
        else if (cnt == 32'd0) state_nxt = timeout_pick(open_dirs);
`endif
      end
      ST_TURN_L, ST_TURN_R, ST_TURN_BACK: begin
        if (cnt == 32'd0) state_nxt = ST_FORWARD;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!enable) state_nxt = ST_IDLE;
  end

  // Shared down-counter: saturates at 0 and reloads on every state entry
  always_comb begin
    cnt_nxt = (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
    if (state_nxt != state) cnt_nxt = load_for(state_nxt);
  end

  // State, counter and registered outputs all advance together
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= 32'd0;
      moving_state <= MS_STOP;
      waiting      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      moving_state <= ms_for_state(state_nxt);
      waiting      <= (state_nxt == ST_WAIT_CMD);
    end
  end

  assign nav_state = state;

endmodule
